ss_adc_ctrl: RTL and testbench

//  Conversion sequencer for a single-slope ADC built around counter_half.
//  On start it loads the counter with a per-conversion offset, settles the ramp, then

---
 rtl/ss_adc_ctrl.sv | 127 ++++++++++++
 tb/tb_ss_adc_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ss_adc_ctrl.sv
// ss_adc_ctrl: single-slope ADC conversion sequencer driving an external counter_half
// and ramp, with a synchronised comparator and a valid/ready result port.
module ss_adc_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_offset,
    input  logic             cmp,
    input  logic [WIDTH-1:0] cnt_count,
    input  logic             cnt_ovf,
    output logic             cnt_rst,
    output logic             cnt_set,
    output logic [WIDTH-1:0] cnt_setval,
    output logic             cnt_en,
    output logic             ramp_rst,
    output logic             ramp_en,
    output logic             busy,
    output logic [WIDTH-1:0] res_data,
    output logic             res_sat,
    output logic             res_valid,
    input  logic             res_ready
);
    localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {IDLE, PRESET, SETTLE, CONVERT, ERRHI, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] off_q, off_d, res_data_q, res_data_d;
    logic             res_sat_q, res_sat_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic             cmp_s;

    assign cmp_s      = sync_q[SYNC_STAGES-1];
    assign sync_d     = {sync_q[SYNC_STAGES-2:0], cmp};
    assign cnt_setval = off_q;
    assign busy       = state_q != IDLE;
    assign res_data   = res_data_q;
    assign res_sat    = res_sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            off_q      <= '0;
            res_data_q <= '0;
            res_sat_q  <= 1'b0;
            settle_q   <= '0;
            sync_q     <= '0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            res_data_q <= res_data_d;
            res_sat_q  <= res_sat_d;
            settle_q   <= settle_d;
            sync_q     <= sync_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        res_data_d = res_data_q;
        res_sat_d  = res_sat_q;
        settle_d   = settle_q;
        cnt_rst    = 1'b0;
        cnt_set    = 1'b0;
        cnt_en     = 1'b0;
        ramp_rst   = 1'b0;
        ramp_en    = 1'b0;
        res_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_rst  = 1'b1;
                ramp_rst = 1'b1;
                if (start) begin
                    off_d   = cfg_offset;
                    state_d = PRESET;
                end
            end
            PRESET: begin
                cnt_set  = 1'b1;
                ramp_rst = 1'b1;
                settle_d = SW'(SETTLE_CYC - 1);
                state_d  = SETTLE;
            end
            SETTLE: begin
                ramp_rst = 1'b1;
                settle_d = settle_q - SW'(1);
                if (settle_q == '0)
                    state_d = cmp_s ? ERRHI : CONVERT;
            end
            CONVERT: begin
                ramp_en = 1'b1;
                cnt_en  = 1'b1;
                // overflow has priority so a wrapped count of 0 is never reported
                if (cnt_ovf) begin
                    res_data_d = '1;
                    res_sat_d  = 1'b1;
                    state_d    = DONE;
                end else if (cmp_s) begin
                    res_data_d = cnt_count;
                    res_sat_d  = 1'b0;
                    state_d    = DONE;
                end
            end
            ERRHI: begin
                ramp_rst   = 1'b1;
                res_data_d = off_q;
                res_sat_d  = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                ramp_rst  = 1'b1;
                if (res_ready) begin
                    off_d   = start ? cfg_offset : off_q;
                    state_d = start ? PRESET : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ss_adc_ctrl.sv
// tb_ss_adc_ctrl: directed and randomized checks of ss_adc_ctrl against a
// cycle-count model of the conversion, with a behavioural counter_half attached.
module tb_ss_adc_ctrl;
    localparam int W  = 8;
    localparam int S  = 4;
    localparam int SS = 2;
    localparam int FS = 1 << W;

    logic         clk = 1'b0;
    logic         rst, start, cmp, res_ready;
    logic [W-1:0] cfg_offset, cnt_count, cnt_setval, res_data;
    logic         cnt_ovf, cnt_rst, cnt_set, cnt_en, ramp_rst, ramp_en, busy, res_sat, res_valid;
    logic         watch = 1'b0, seen_en = 1'b0;
    int           tests = 0, fails = 0;

    ss_adc_ctrl #(.WIDTH(W), .SETTLE_CYC(S), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_offset(cfg_offset), .cmp(cmp),
        .cnt_count(cnt_count), .cnt_ovf(cnt_ovf), .cnt_rst(cnt_rst), .cnt_set(cnt_set),
        .cnt_setval(cnt_setval), .cnt_en(cnt_en), .ramp_rst(ramp_rst), .ramp_en(ramp_en),
        .busy(busy), .res_data(res_data), .res_sat(res_sat), .res_valid(res_valid),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // counter_half: wraps at 2^W, flagging ovf for the one cycle the count reads 0
    always_ff @(posedge clk) begin
        if (cnt_rst) begin
            cnt_count <= '0;
            cnt_ovf   <= 1'b0;
        end else if (cnt_set) begin
            cnt_count <= cnt_setval;
            cnt_ovf   <= 1'b0;
        end else if (cnt_en) begin
            {cnt_ovf, cnt_count} <= {1'b0, cnt_count} + (W + 1)'(1);
        end else begin
            cnt_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) seen_en <= watch ? (seen_en | cnt_en) : 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] off);
        cfg_offset = off;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        cfg_offset = W'($urandom);
    endtask

    // Entered just after the edge that moved into PRESET; cmp rises j cycles into CONVERT.
    task automatic do_conv(input logic [W-1:0] off, input int j);
        int n, k, code, exp_n;
        chk("preset_set", cnt_set, 1);
        chk("preset_val", cnt_setval, off);
        tick(S + 1);
        chk("convert_en", {cnt_en, ramp_en}, 2'b11);
        n = 0;
        while (!res_valid && n < FS + 50) begin
            if (n == j) cmp = 1'b1;
            tick(1);
            n++;
        end
        code  = int'(off) + j + SS;
        k     = (j + SS < FS - int'(off)) ? j + SS : FS - int'(off);
        exp_n = k + 1;
        chk("done_valid", res_valid, 1);
        chk("done_latency", n, exp_n);
        chk("done_sat", res_sat, code >= FS);
        chk("done_data", res_data, code >= FS ? FS - 1 : code);
        cmp = 1'b0;
    endtask

    // Holds the result for 'hold' cycles with stray start pulses, then hands it off.
    task automatic finish(input int hold, input logic b2b, input logic [W-1:0] noff);
        logic [W-1:0] d;
        logic         s;
        d = res_data;
        s = res_sat;
        for (int i = 0; i < hold; i++) begin
            start = i[0];
            cfg_offset = W'($urandom);
            tick(1);
            chk("hold_valid", res_valid, 1);
            chk("hold_data", {res_sat, res_data}, {s, d});
        end
        start = b2b;
        cfg_offset = noff;
        res_ready = 1'b1;
        tick(1);
        start = 1'b0;
        res_ready = 1'b0;
        chk("post_valid", res_valid, 0);
        chk("post_busy", busy, b2b);
        chk("post_cntrst", cnt_rst, !b2b);
        chk("post_result", {res_sat, res_data}, {s, d});
    endtask

    initial begin
        logic [W-1:0] off, noff;
        logic         b2b, pend;
        int           j, n;
        rst = 1'b1; start = 1'b0; cmp = 1'b0; res_ready = 1'b0; cfg_offset = '0;
        tick(2);
        chk("rst_outs", {cnt_rst, ramp_rst, busy, res_valid, cnt_set, cnt_en, ramp_en, res_sat},
            8'b1100_0000);
        chk("rst_data", res_data, 0);
        rst = 1'b0;
        tick(1);

        launch(0);
        do_conv(0, 20);
        finish(0, 0, 0);

        launch(250);
        do_conv(250, 1000);
        finish(1, 0, 0);

        launch(255);
        do_conv(255, 0);
        finish(0, 0, 0);

        cmp = 1'b1;
        watch = 1'b1;
        launch(8'h5a);
        n = 0;
        while (!res_valid && n < 40) begin
            tick(1);
            n++;
        end
        chk("errhi_latency", n, S + 2);
        chk("errhi_result", {res_sat, res_data}, {1'b1, 8'h5a});
        chk("errhi_no_en", seen_en, 0);
        watch = 1'b0;
        cmp = 1'b0;
        finish(0, 0, 0);

        launch(8'h10);
        do_conv(8'h10, 7);
        finish(10, 1, 8'h33);
        chk("b2b_set", {cnt_set, cnt_setval}, {1'b1, 8'h33});
        do_conv(8'h33, 3);
        finish(0, 0, 0);

        launch(8'h40);
        tick(S + 1 + 3);
        chk("mid_convert", cnt_en, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst", {busy, cnt_rst, res_valid, cnt_en}, 4'b0100);
        chk("mid_rst_data", res_data, 0);
        tick(5);
        chk("mid_rst_idle", {busy, res_valid}, 2'b00);

        pend = 1'b0;
        noff = '0;
        for (int it = 0; it < 24; it++) begin
            off = pend ? noff : ($urandom_range(0, 1) ? W'($urandom_range(200, 255)) : W'($urandom));
            j   = $urandom_range(0, 7) == 0 ? 1000 : $urandom_range(0, 60);
            if (!pend) launch(off);
            do_conv(off, j);
            b2b  = it < 23 && $urandom_range(0, 1) == 1;
            noff = W'($urandom);
            finish($urandom_range(0, 3), b2b, noff);
            pend = b2b;
            if (!b2b) tick($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
